// File: rtl/interrupt_request_gen.sv
// Interrupt request front end: NMI edge detection, reset-button synchronise/debounce,
// halt-aware deferral of single-cycle request pulses, and NMI diagnostics.
module interrupt_request_gen #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter bit          POWER_ON_REQ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblank_flag,
  input  logic       nmi_enable,
  input  logic       reset_button_n,
  input  logic       halt,
  output logic [7:0] ppu_status_out,
  output logic       soft_reset_n,
  output logic       nmi_pending,
  output logic       button_state,
  output logic [7:0] nmi_count,
  output logic       nmi_dropped
);

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_PRESS_QUAL,
    BTN_HELD,
    BTN_RELEASE_QUAL
  } btn_state_t;

  logic        sync1, sync2;
  logic        btn_s, btn_s_q;
  logic [15:0] deb_cnt;
  logic        deb_done;
  btn_state_t  btn_st;
  logic        press_accept;

  logic        nmi_line, nmi_line_q, nmi_edge;
  logic        nmi_pulse;
  logic        rst_pending;

  assign btn_s        = ~sync2;
  assign deb_done     = (deb_cnt == DEBOUNCE_CYCLES);
  assign press_accept = (btn_st == BTN_PRESS_QUAL) && btn_s && deb_done;

  assign nmi_line       = vblank_flag & nmi_enable;
  assign nmi_edge       = nmi_line & ~nmi_line_q;
  assign ppu_status_out = {nmi_pulse, 7'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      btn_s_q <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1   <= reset_button_n;
      sync2   <= sync1;
      btn_s_q <= btn_s;
      if (btn_s != btn_s_q)
        deb_cnt <= '0;
      else if (!deb_done)
        deb_cnt <= deb_cnt + 16'd1;
    end
  end

  // Entering a qualify state always coincides with a btn_s change, so the
  // counter restarts from zero without an explicit clear from the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_st       <= BTN_IDLE;
      button_state <= 1'b0;
    end else begin
      unique case (btn_st)
        BTN_IDLE:
          if (btn_s) btn_st <= BTN_PRESS_QUAL;
        BTN_PRESS_QUAL:
          if (!btn_s) begin
            btn_st <= BTN_IDLE;
          end else if (deb_done) begin
            btn_st       <= BTN_HELD;
            button_state <= 1'b1;
          end
        BTN_HELD:
          if (!btn_s) btn_st <= BTN_RELEASE_QUAL;
        BTN_RELEASE_QUAL:
          if (btn_s) begin
            btn_st <= BTN_HELD;
          end else if (deb_done) begin
            btn_st       <= BTN_IDLE;
            button_state <= 1'b0;
          end
        default: btn_st <= BTN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_line_q  <= 1'b0;
      nmi_pulse   <= 1'b0;
      nmi_pending <= 1'b0;
      nmi_count   <= '0;
      nmi_dropped <= 1'b0;
    end else begin
      nmi_line_q <= nmi_line;
      if (nmi_edge && nmi_pending)
        nmi_dropped <= 1'b1;
      if (!halt) begin
        nmi_pulse   <= nmi_edge | nmi_pending;
        nmi_pending <= 1'b0;
        if (nmi_edge || nmi_pending)
          nmi_count <= nmi_count + 8'd1;
      end else begin
        nmi_pulse   <= 1'b0;
        nmi_pending <= nmi_pending | nmi_edge;
      end
    end
  end

  // The power-on request is simply the reset value of the pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      soft_reset_n <= 1'b1;
      rst_pending  <= POWER_ON_REQ;
    end else if (!halt) begin
      soft_reset_n <= ~rst_pending;
      rst_pending  <= press_accept & ~rst_pending;
    end else begin
      soft_reset_n <= 1'b1;
      rst_pending  <= rst_pending | press_accept;
    end
  end

endmodule

// File: tb/tb_interrupt_request_gen.sv
// Directed bench for interrupt_request_gen with DEBOUNCE_CYCLES=4, POWER_ON_REQ=1.
module tb_interrupt_request_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblank_flag, nmi_enable, reset_button_n, halt;
  logic [7:0] ppu_status_out;
  logic       soft_reset_n, nmi_pending, button_state, nmi_dropped;
  logic [7:0] nmi_count;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  logic [7:0]  exp_count = 8'd0;

  interrupt_request_gen #(
    .DEBOUNCE_CYCLES(16'd4),
    .POWER_ON_REQ(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vblank_flag(vblank_flag),
    .nmi_enable(nmi_enable),
    .reset_button_n(reset_button_n),
    .halt(halt),
    .ppu_status_out(ppu_status_out),
    .soft_reset_n(soft_reset_n),
    .nmi_pending(nmi_pending),
    .button_state(button_state),
    .nmi_count(nmi_count),
    .nmi_dropped(nmi_dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vblank_flag = 1'b0; nmi_enable = 1'b0;
    reset_button_n = 1'b1; halt = 1'b0;
    tick(); tick();
    tests_run++;
    if ({ppu_status_out, soft_reset_n, nmi_pending, button_state, nmi_count, nmi_dropped}
        !== {8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: status=%h srn=%b pend=%b btn=%b cnt=%0d drop=%b, required 00 1 0 0 0 0",
               ppu_status_out, soft_reset_n, nmi_pending, button_state, nmi_count, nmi_dropped);
    end
  endtask

  task automatic test_power_on();
    int unsigned lows = 0;
    rst = 1'b0;
    tick();
    tests_run++;
    if (soft_reset_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL power_on_pulse: soft_reset_n=%b required 0", soft_reset_n);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (soft_reset_n === 1'b0 || ppu_status_out !== 8'h00) lows++;
    end
    tests_run++;
    if (lows != 0) begin
      tests_failed++;
      $display("FAIL power_on_single: extra activity cycles=%0d required 0", lows);
    end
  endtask

  task automatic test_nmi_vblank_edge();
    int unsigned extra = 0;
    nmi_enable = 1'b1; vblank_flag = 1'b0;
    tick();
    vblank_flag = 1'b1;
    tick();
    exp_count = exp_count + 8'd1;
    tests_run++;
    if (ppu_status_out !== 8'h80) begin
      tests_failed++;
      $display("FAIL nmi_vblank_pulse: status=%h required 80", ppu_status_out);
    end
    tests_run++;
    if (nmi_count !== exp_count) begin
      tests_failed++;
      $display("FAIL nmi_vblank_count: count=%0d required %0d", nmi_count, exp_count);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ppu_status_out !== 8'h00) extra++;
    end
    tests_run++;
    if (extra != 0 || nmi_count !== exp_count) begin
      tests_failed++;
      $display("FAIL nmi_vblank_hold: extra=%0d count=%0d required 0 and %0d", extra, nmi_count, exp_count);
    end
  endtask

  task automatic test_nmi_enable_edge();
    int unsigned extra = 0;
    nmi_enable = 1'b0; vblank_flag = 1'b1;
    tick(); tick();
    tests_run++;
    if (ppu_status_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL nmi_disabled: status=%h required 00", ppu_status_out);
    end
    nmi_enable = 1'b1;
    tick();
    exp_count = exp_count + 8'd1;
    tests_run++;
    if (ppu_status_out !== 8'h80 || nmi_count !== exp_count) begin
      tests_failed++;
      $display("FAIL nmi_enable_pulse: status=%h count=%0d required 80 and %0d", ppu_status_out, nmi_count, exp_count);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ppu_status_out !== 8'h00) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("FAIL nmi_enable_single: extra=%0d required 0", extra);
    end
  endtask

  task automatic test_halt_merge();
    int unsigned early = 0;
    vblank_flag = 1'b0; halt = 1'b1;
    tick();
    vblank_flag = 1'b1;
    tick();
    tests_run++;
    if (nmi_pending !== 1'b1 || ppu_status_out !== 8'h00 || nmi_dropped !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_defer: pend=%b status=%h drop=%b required 1 00 0", nmi_pending, ppu_status_out, nmi_dropped);
    end
    vblank_flag = 1'b0;
    tick();
    nmi_enable = 1'b0;
    tick();
    vblank_flag = 1'b1; nmi_enable = 1'b1;
    tick();
    tests_run++;
    if (nmi_pending !== 1'b1 || nmi_dropped !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_second_edge: pend=%b drop=%b required 1 1", nmi_pending, nmi_dropped);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ppu_status_out !== 8'h00) early++;
    end
    halt = 1'b0;
    tick();
    exp_count = exp_count + 8'd1;
    tests_run++;
    if (early != 0 || ppu_status_out !== 8'h80 || nmi_count !== exp_count || nmi_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_release: early=%0d status=%h count=%0d pend=%b required 0 80 %0d 0",
               early, ppu_status_out, nmi_count, nmi_pending, exp_count);
    end
    tick();
    tests_run++;
    if (ppu_status_out !== 8'h00 || nmi_dropped !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_after: status=%h drop=%b required 00 1", ppu_status_out, nmi_dropped);
    end
  endtask

  task automatic test_button();
    int unsigned pulses = 0;
    int unsigned early_state = 0;
    logic [11:0] bounce = 12'b110011001100;
    for (int i = 0; i < 12; i++) begin
      reset_button_n = bounce[i];
      tick();
      if (button_state !== 1'b0) early_state++;
      if (soft_reset_n === 1'b0) pulses++;
    end
    tests_run++;
    if (early_state != 0 || pulses != 0) begin
      tests_failed++;
      $display("FAIL button_bounce: state_hi=%0d pulses=%0d required 0 0", early_state, pulses);
    end
    reset_button_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (soft_reset_n === 1'b0) pulses++;
    end
    tests_run++;
    if (button_state !== 1'b1 || pulses != 1) begin
      tests_failed++;
      $display("FAIL button_press: state=%b pulses=%0d required 1 1", button_state, pulses);
    end
    pulses = 0;
    reset_button_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (soft_reset_n === 1'b0) pulses++;
    end
    tests_run++;
    if (button_state !== 1'b0 || pulses != 0) begin
      tests_failed++;
      $display("FAIL button_release: state=%b pulses=%0d required 0 0", button_state, pulses);
    end
  endtask

  task automatic test_reset_midop();
    int unsigned bad = 0;
    vblank_flag = 1'b0; nmi_enable = 1'b1; halt = 1'b1;
    tick();
    vblank_flag = 1'b1;
    tick();
    tests_run++;
    if (nmi_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_pending: pend=%b required 1", nmi_pending);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({ppu_status_out, soft_reset_n, nmi_pending, button_state, nmi_count, nmi_dropped}
        !== {8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL midop_async_reset: status=%h srn=%b pend=%b btn=%b cnt=%0d drop=%b, required 00 1 0 0 0 0",
               ppu_status_out, soft_reset_n, nmi_pending, button_state, nmi_count, nmi_dropped);
    end
    halt = 1'b0; vblank_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ppu_status_out !== 8'h00 || soft_reset_n !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL midop_quiet_in_reset: bad_cycles=%0d required 0", bad);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (soft_reset_n !== 1'b0 || ppu_status_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL midop_power_on: srn=%b status=%h required 0 00", soft_reset_n, ppu_status_out);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ppu_status_out !== 8'h00 || soft_reset_n !== 1'b1 || nmi_pending !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || nmi_count !== 8'h00) begin
      tests_failed++;
      $display("FAIL midop_after: bad_cycles=%0d count=%0d required 0 0", bad, nmi_count);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_nmi_vblank_edge();
    test_nmi_enable_edge();
    test_halt_merge();
    test_button();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
